// File: rtl/auto_range_pkg.sv
// Shared encodings and width helpers for the auto-ranging controller.
// AUTO_RANGE_HOLD_EN (optional macro) adds a hold input to auto_range_ctrl.
package auto_range_pkg;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_SETTLE = 1'b1;

   typedef enum logic {
      IDLE   = ST_IDLE,
      SETTLE = ST_SETTLE
   } state_t;

   // Hysteresis counter must hold values 0..hyst
   function automatic int hyst_w(input int hyst);
      return (hyst < 1) ? 1 : $clog2(hyst + 1);
   endfunction

   // A zero-length settle window still needs a 1-bit counter
   function automatic int settle_w(input int settle_cyc);
      return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
   endfunction

endpackage

// File: rtl/range_settle_timer.sv
// Loadable down-counter; done is high while the final count cycle (or idle zero) is present,
// so the owner leaves its settle state exactly load_val cycles after loading.
module range_settle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset || load)
         count_reg <= load_val;
      else if (count_reg != '0)
         count_reg <= count_reg - W'(1);
   end

   assign done = (count_reg <= W'(1));

endmodule

// File: rtl/auto_range_ctrl.sv
// Auto-ranging controller: hysteresis-qualified range stepping, settle window, end saturation flag.
// Optional macro AUTO_RANGE_HOLD_EN adds a hold input that freezes switching and counters.
module auto_range_ctrl
   import auto_range_pkg::*;
#(
   parameter int NUM_RANGES = 4,
   parameter int RANGE_W    = 2,
   parameter int INIT_RANGE = 0,
   parameter int HYST       = 2,
   parameter int SETTLE_CYC = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               meas_valid,
   input  logic               cnt_over,
   input  logic               cnt_low,
`ifdef AUTO_RANGE_HOLD_EN
   input  logic               hold,
`endif
   output logic [RANGE_W-1:0] out,
   output logic               c_out,
   output logic               range_valid,
   output logic               switching
);

   localparam int HW = hyst_w(HYST);
   localparam int SW = settle_w(SETTLE_CYC);
   localparam logic [HW-1:0]      HYST_V = HW'(HYST);
   localparam logic [RANGE_W-1:0] TOP_V  = RANGE_W'(NUM_RANGES - 1);
   localparam logic [RANGE_W-1:0] INIT_V = RANGE_W'(INIT_RANGE);

   state_t        state_reg;
   logic [HW-1:0] up_cnt_reg, dn_cnt_reg;
   logic [HW-1:0] up_next, dn_next;
   logic          hold_act, up_hit, dn_hit, at_top, at_bot;
   logic          meas_ok, is_up, is_dn, go_up, go_dn, sat_hit, hold_sat, settle_done;

`ifdef AUTO_RANGE_HOLD_EN
   assign hold_act = hold;
`else
   assign hold_act = 1'b0;
`endif

   // Counters saturate at HYST so a held end-range condition keeps re-qualifying
   assign up_next = (up_cnt_reg == HYST_V) ? HYST_V : up_cnt_reg + HW'(1);
   assign dn_next = (dn_cnt_reg == HYST_V) ? HYST_V : dn_cnt_reg + HW'(1);
   assign up_hit  = (up_next == HYST_V);
   assign dn_hit  = (dn_next == HYST_V);
   assign at_top  = (out == TOP_V);
   assign at_bot  = (out == '0);

   assign meas_ok  = (state_reg == IDLE) && meas_valid && !clr && !hold_act;
   assign is_up    = meas_ok && cnt_over;
   assign is_dn    = meas_ok && !cnt_over && cnt_low;
   assign go_up    = is_up && up_hit && !at_top;
   assign go_dn    = is_dn && dn_hit && !at_bot;
   assign hold_sat = (state_reg == IDLE) && meas_valid && !clr && hold_act &&
                     ((cnt_over && at_top) || (!cnt_over && cnt_low && at_bot));
   assign sat_hit  = (is_up && up_hit && at_top) || (is_dn && dn_hit && at_bot) || hold_sat;

   assign range_valid = (state_reg != SETTLE);

   range_settle_timer #(.W(SW)) u_settle (
      .clk      (clk),
      .reset    (reset),
      .load     (go_up || go_dn),
      .load_val (SW'(SETTLE_CYC)),
      .done     (settle_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out        <= INIT_V;
         c_out      <= 1'b0;
         switching  <= 1'b0;
         up_cnt_reg <= '0;
         dn_cnt_reg <= '0;
         state_reg  <= (SETTLE_CYC == 0) ? IDLE : SETTLE;
      end else begin
         switching <= go_up || go_dn;

         if (go_up)
            out <= out + RANGE_W'(1);
         else if (go_dn)
            out <= out - RANGE_W'(1);

         if (clr)
            c_out <= 1'b0;
         else if (sat_hit)
            c_out <= 1'b1;

         if (state_reg == SETTLE) begin
            if (settle_done)
               state_reg <= IDLE;
         end else if ((go_up || go_dn) && SETTLE_CYC != 0) begin
            state_reg <= SETTLE;
         end

         if (clr || state_reg == SETTLE || go_up || go_dn) begin
            up_cnt_reg <= '0;
            dn_cnt_reg <= '0;
         end else if (is_up) begin
            up_cnt_reg <= up_next;
            dn_cnt_reg <= '0;
         end else if (is_dn) begin
            dn_cnt_reg <= dn_next;
            up_cnt_reg <= '0;
         end else if (meas_ok) begin
            up_cnt_reg <= '0;
            dn_cnt_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_auto_range_ctrl.sv
// Table-driven bench for auto_range_ctrl with an expectation queue; extra hand sequences
// cover settle timing under clr and (with AUTO_RANGE_HOLD_EN) the hold input.
module tb_auto_range_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0, clr = 1'b0, meas_valid = 1'b0, cnt_over = 1'b0, cnt_low = 1'b0;
`ifdef AUTO_RANGE_HOLD_EN
   logic       hold = 1'b0;
`endif
   logic [1:0] out;
   logic       c_out, range_valid, switching;

   int n_cmp = 0;
   int n_bad = 0;

   // in  = {reset, clr, meas_valid, cnt_over, cnt_low}
   // exp = {out[1:0], c_out, range_valid, switching}
   typedef struct {
      logic [4:0] in;
      logic [4:0] ex;
   } vec_t;

   typedef struct {
      logic [4:0] ex;
      string      tag;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   always #5 clk = ~clk;

   auto_range_ctrl #(
      .NUM_RANGES (4),
      .RANGE_W    (2),
      .INIT_RANGE (0),
      .HYST       (2),
      .SETTLE_CYC (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .meas_valid  (meas_valid),
      .cnt_over    (cnt_over),
      .cnt_low     (cnt_low),
`ifdef AUTO_RANGE_HOLD_EN
      .hold        (hold),
`endif
      .out         (out),
      .c_out       (c_out),
      .range_valid (range_valid),
      .switching   (switching)
   );

   task automatic add(input logic [4:0] in, input logic [4:0] ex);
      vec_t v;
      v.in = in;
      v.ex = ex;
      vecs.push_back(v);
   endtask

   task automatic check_bit(input string tag, input string field, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s %s: got %b want %b", tag, field, got, want);
      end
   endtask

   task automatic compare_head();
      sb_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if (out !== e.ex[4:3]) begin
         n_bad++;
         $display("FAIL %s out: got %0d want %0d", e.tag, out, e.ex[4:3]);
      end
      check_bit(e.tag, "c_out", c_out, e.ex[2]);
      check_bit(e.tag, "range_valid", range_valid, e.ex[1]);
      check_bit(e.tag, "switching", switching, e.ex[0]);
      $display("step %-10s in: rst=%b clr=%b mv=%b ov=%b lo=%b -> out=%0d c=%b rv=%b sw=%b",
               e.tag, reset, clr, meas_valid, cnt_over, cnt_low, out, c_out, range_valid, switching);
   endtask

   task automatic step(input logic [4:0] in, input logic [4:0] ex, input string tag);
      sb_t e;
      {reset, clr, meas_valid, cnt_over, cnt_low} = in;
      e.ex  = ex;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   initial begin
      int ticks;
      logic rv_seen;

      // Reset and settle
      add(5'b10000, 5'b00000);
      add(5'b00000, 5'b00000);
      add(5'b00000, 5'b00000);
      add(5'b00000, 5'b00010);
      // Two over strobes step 0->1; strobes during settle ignored
      add(5'b00110, 5'b00010);
      add(5'b00110, 5'b01001);
      add(5'b00110, 5'b01000);
      add(5'b00110, 5'b01000);
      add(5'b00000, 5'b01010);
      // over, none, over keeps range; over, over steps to 2
      add(5'b00110, 5'b01010);
      add(5'b00100, 5'b01010);
      add(5'b00110, 5'b01010);
      add(5'b00110, 5'b10001);
      add(5'b00000, 5'b10000);
      add(5'b00000, 5'b10000);
      add(5'b00000, 5'b10010);
      // Step to the top range, then saturate
      add(5'b00110, 5'b10010);
      add(5'b00110, 5'b11001);
      add(5'b00000, 5'b11000);
      add(5'b00000, 5'b11000);
      add(5'b00000, 5'b11010);
      add(5'b00110, 5'b11010);
      add(5'b00110, 5'b11110);
      // clr, then clr colliding with an over strobe must not count
      add(5'b01000, 5'b11010);
      add(5'b01110, 5'b11010);
      add(5'b00110, 5'b11010);
      add(5'b00110, 5'b11110);
      // Step down keeps sticky c_out; reset mid-settle at out=2
      add(5'b00101, 5'b11110);
      add(5'b00101, 5'b10101);
      add(5'b00000, 5'b10100);
      add(5'b10000, 5'b00000);
      add(5'b00000, 5'b00000);
      add(5'b00000, 5'b00000);
      add(5'b00000, 5'b00010);
      // over and low together count as over
      add(5'b00111, 5'b00010);
      add(5'b00111, 5'b01001);
      add(5'b00000, 5'b01000);
      add(5'b00000, 5'b01000);
      add(5'b00000, 5'b01010);
      // Step back to 0, then saturate at the bottom
      add(5'b00101, 5'b01010);
      add(5'b00101, 5'b00001);
      add(5'b00000, 5'b00000);
      add(5'b00000, 5'b00000);
      add(5'b00000, 5'b00010);
      add(5'b00101, 5'b00010);
      add(5'b00101, 5'b00110);
      add(5'b00101, 5'b00110);
      add(5'b00000, 5'b00110);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].in, vecs[i].ex, $sformatf("vec%0d", i));

      // clr inside a settle window must not stretch or shorten it
      step(5'b00110, 5'b00110, "hs_up1");
      step(5'b00110, 5'b01101, "hs_up2");
      step(5'b01000, 5'b01000, "hs_clr");
      {reset, clr, meas_valid, cnt_over, cnt_low} = 5'b00000;
      ticks = 0;
      rv_seen = 1'b0;
      for (int t = 0; t < 10 && !rv_seen; t++) begin
         @(posedge clk);
         #1;
         ticks++;
         rv_seen = range_valid;
      end
      n_cmp++;
      if (!rv_seen || ticks != 2) begin
         n_bad++;
         $display("FAIL settle_after_clr: got %0d cycles (seen=%b) want 2", ticks, rv_seen);
      end
      step(5'b00000, 5'b01010, "hs_idle");

`ifdef AUTO_RANGE_HOLD_EN
      hold = 1'b1;
      for (int k = 0; k < 4; k++)
         step(5'b00110, 5'b01010, $sformatf("hold%0d", k));
      hold = 1'b0;
      step(5'b00110, 5'b01010, "unhold1");
      step(5'b00110, 5'b10001, "unhold2");
`endif

      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
